timer_param_ctrl: RTL and testbench
===================================

// Module: timer_param_ctrl
// PURPOSE
//  Owns the anti-theft system's timing resource. It holds four programmable time
//  parameters and generates the 1 Hz enable. On start_timer it loads the parameter
//  chosen by interval, counts it down in seconds and pulses expired.
//  Sits beside the system FSM, which drives start_timer/interval/reprogram and
//  consumes expired/one_hz_enable.
// PARAMETERS
//  CLK_HZ  50_000_000  clock cycles per second (bench uses 4)
//  TIME_W  4           width of a time parameter, in seconds
// PORTS
//  clock           in   1       system clock, rising edge
//  reset           in   1       asynchronous, active-high
//  start_timer     in   1       one-cycle pulse: load interval's param, start count
//  interval        in   2       00 T_ARM_DELAY, 01 T_DRIVER_DELAY, 10 T_PASSENGER_DELAY, 11 T_ALARM_ON
//  reprogram       in   1       level: write time_value into param time_param_sel; aborts count
//  time_param_sel  in   2       parameter select, same encoding as interval
//  time_value      in   TIME_W  new value in seconds, 0..15 all legal
//  expired         out  1       one-cycle pulse at end of interval
//  one_hz_enable   out  1       one-cycle pulse every CLK_HZ cycles
//  remaining       out  TIME_W  seconds left (0 when idle)
//  counting        out  1       high while a countdown is active
// BEHAVIOUR
//  Reset (async): T_ARM_DELAY=6, T_DRIVER_DELAY=8, T_PASSENGER_DELAY=15,
//   T_ALARM_ON=10; div=0; state IDLE; expired=0, counting=0, remaining=0.
//  Divider: div counts 0..CLK_HZ-1 and wraps.
//   one_hz_enable = (div==CLK_HZ-1), decoded from the register.
//   start_timer accepted -> div<=0, so the first tick comes exactly CLK_HZ cycles after start.
//  FSM states IDLE, COUNT:
//   IDLE + start_timer: remaining<=param[interval]. If the value is 0, expired<=1 and stay IDLE.
//    Otherwise counting<=1 and go to COUNT.
//   COUNT + one_hz_enable:
//    remaining==1 -> remaining<=0, expired<=1, counting<=0, go to IDLE.
//    otherwise remaining<=remaining-1.
//   COUNT + start_timer: restart with the new interval's value. This beats a tick in the same cycle.
//   COUNT + reprogram: abort. remaining<=0, counting<=0, go to IDLE, no expired pulse.
//  Timing: for value N>0, expired is registered high for one cycle starting N*CLK_HZ
//   edges after the start edge. It is never high two cycles in a row.
//  Reprogram: on every cycle with reprogram=1, param[time_param_sel]<=time_value.
//   reprogram and start_timer in the same cycle: write is performed, start is ignored.
//  A param written during a count does not affect that count; it is read only at load.
//  remaining never wraps below 0. Decrement happens only in COUNT with remaining>=1.
//  Reset asserted mid-count: immediate return to the reset values, params back to defaults.
// STRUCTURE
//  Shared package/header (`include): interval codes INT_ARM, INT_DRIVER, INT_PASS,
//   INT_ALARM; default times DEF_ARM=6, DEF_DRIVER=8, DEF_PASS=15, DEF_ALARM=10;
//   state codes IDLE/COUNT.
//  Sub-module one_hz_divider (clock, reset, clear -> tick), parameter CLK_HZ.
//   Also reusable for the status LED blink.
//  Top holds the 4 x TIME_W parameter bank, the countdown register and the FSM.
// TESTING (CLK_HZ=4)
//  1. Reset, pulse start_timer with interval=01 -> counting=1, remaining=8;
//     expired pulses exactly 32 cycles after the start edge; remaining=0 after.
//  2. reprogram=1 for 1 cycle with sel=10, value=3, then start with interval=10 ->
//     expired after 12 cycles; other params still 6/8/10.
//  3. Write value 0 to sel=00, start with interval=00 -> expired high the next cycle
//     only; counting stays 0.
//  4. Start with interval=11 (10 s), restart with interval=00 at cycle 9 ->
//     expired 24 cycles after the second start, no earlier pulse.
//  5. Start with interval=01, reprogram at cycle 10 -> counting=0, remaining=0,
//     no expired; same-cycle start+reprogram -> write only, no count.
//  6. Write sel=01, value=2, then assert reset mid-count -> all outputs 0;
//     next start with interval=01 loads 8 (default restored).

Source files
------------

// File: rtl/timer_param_ctrl_pkg.sv
// Shared codes for the anti-theft timing block: interval selects, reset-default
// parameter values in seconds, and countdown FSM states.
package timer_param_ctrl_pkg;

  localparam logic [1:0] INT_ARM    = 2'b00;
  localparam logic [1:0] INT_DRIVER = 2'b01;
  localparam logic [1:0] INT_PASS   = 2'b10;
  localparam logic [1:0] INT_ALARM  = 2'b11;

  localparam int DEF_ARM    = 6;
  localparam int DEF_DRIVER = 8;
  localparam int DEF_PASS   = 15;
  localparam int DEF_ALARM  = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/timer_param_ctrl_divider.sv
// Free-running divider: tick is high for one cycle when the count sits at CLK_HZ-1.
// clear restarts the count at 0, so the next tick lands exactly CLK_HZ cycles later.
module one_hz_divider #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_HZ - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (clear || div == LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/timer_param_ctrl.sv
// Anti-theft timing resource: four programmable second-counts, a 1 Hz enable,
// and a countdown that pulses expired at the end of the selected interval.
module timer_param_ctrl
  import timer_param_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int TIME_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_timer,
  input  logic [1:0]        interval,
  input  logic              reprogram,
  input  logic [1:0]        time_param_sel,
  input  logic [TIME_W-1:0] time_value,
  output logic              expired,
  output logic              one_hz_enable,
  output logic [TIME_W-1:0] remaining,
  output logic              counting
);

  state_t            state, state_nxt;
  logic [TIME_W-1:0] params [4];
  logic [TIME_W-1:0] remaining_nxt;
  logic              counting_nxt;
  logic              expired_nxt;
  logic [TIME_W-1:0] load_val;
  logic              start_go;

  // A write cycle swallows any start in the same cycle.
  assign start_go = start_timer && !reprogram;
  assign load_val = params[interval];

  one_hz_divider #(.CLK_HZ(CLK_HZ)) u_div (
    .clock (clock),
    .reset (reset),
    .clear (start_go),
    .tick  (one_hz_enable)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      params[INT_ARM]    <= TIME_W'(DEF_ARM);
      params[INT_DRIVER] <= TIME_W'(DEF_DRIVER);
      params[INT_PASS]   <= TIME_W'(DEF_PASS);
      params[INT_ALARM]  <= TIME_W'(DEF_ALARM);
    end else if (reprogram) begin
      params[time_param_sel] <= time_value;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      counting  <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      counting  <= counting_nxt;
      expired   <= expired_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    counting_nxt  = counting;
    expired_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_go) begin
          remaining_nxt = load_val;
          if (load_val == '0) begin
            expired_nxt = 1'b1;
          end else begin
            counting_nxt = 1'b1;
            state_nxt    = COUNT;
          end
        end
      end
      COUNT: begin
        if (reprogram) begin
          remaining_nxt = '0;
          counting_nxt  = 1'b0;
          state_nxt     = IDLE;
        end else if (start_go) begin
          // Restart outranks a tick landing in the same cycle.
          remaining_nxt = load_val;
          if (load_val == '0) begin
            expired_nxt  = 1'b1;
            counting_nxt = 1'b0;
            state_nxt    = IDLE;
          end
        end else if (one_hz_enable) begin
          if (remaining <= TIME_W'(1)) begin
            remaining_nxt = '0;
            expired_nxt   = 1'b1;
            counting_nxt  = 1'b0;
            state_nxt     = IDLE;
          end else begin
            remaining_nxt = remaining - TIME_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_param_ctrl.sv
// Directed bench for timer_param_ctrl at CLK_HZ=4: a vector table for cycle-level
// behaviour plus hand sequences for the long countdown corner cases.
module tb_timer_param_ctrl;

  localparam int CLK_HZ = 4;
  localparam int TIME_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start_timer = 1'b0;
  logic [1:0]        interval = 2'b00;
  logic              reprogram = 1'b0;
  logic [1:0]        time_param_sel = 2'b00;
  logic [TIME_W-1:0] time_value = '0;
  logic              expired;
  logic              one_hz_enable;
  logic [TIME_W-1:0] remaining;
  logic              counting;

  int n_checks = 0;
  int n_errors = 0;

  timer_param_ctrl #(.CLK_HZ(CLK_HZ), .TIME_W(TIME_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_timer    (start_timer),
    .interval       (interval),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .remaining      (remaining),
    .counting       (counting)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       start;
    logic [1:0] intv;
    logic       reprog;
    logic [1:0] sel;
    logic [3:0] val;
    logic       e_exp;
    logic       e_cnt;
    logic [3:0] e_rem;
    logic       e_tick;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    start_timer = 1'b0;
    reprogram   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic write_param(input logic [1:0] sel, input logic [3:0] val);
    reprogram = 1'b1; time_param_sel = sel; time_value = val;
    step();
    idle_inputs();
  endtask

  task automatic start(input logic [1:0] intv);
    start_timer = 1'b1; interval = intv;
    step();
    idle_inputs();
  endtask

  // Edges after the start edge until the first expired pulse (-1 on timeout).
  task automatic wait_expire(input string name, input int req_edges);
    int seen;
    seen = -1;
    for (int k = 1; k <= req_edges + 8; k++) begin
      step();
      if (expired) begin
        seen = k;
        break;
      end
    end
    check(name, seen, req_edges);
  endtask

  initial begin
    int pulses;

    //            start intv reprog sel val  exp cnt rem tick
    vecs[0]  = '{1'b0, 2'd0, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 1'b1, 2'd3, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[8]  = '{1'b1, 2'd3, 1'b0, 2'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[10] = '{1'b1, 2'd0, 1'b1, 2'd0, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[11] = '{1'b1, 2'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 2'd2, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[13] = '{1'b1, 2'd2, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0};
    vecs[14] = '{1'b1, 2'd1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0};
    vecs[15] = '{1'b1, 2'd1, 1'b1, 2'd1, 4'd8, 1'b0, 1'b0, 4'd0, 1'b0};

    // Reset state
    #2;
    check("rst_expired", expired, 0);
    check("rst_counting", counting, 0);
    check("rst_remaining", remaining, 0);
    check("rst_tick", one_hz_enable, 0);
    step();
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      start_timer    = vecs[i].start;
      interval       = vecs[i].intv;
      reprogram      = vecs[i].reprog;
      time_param_sel = vecs[i].sel;
      time_value     = vecs[i].val;
      step();
      check($sformatf("vec%0d_expired", i), expired, vecs[i].e_exp);
      check($sformatf("vec%0d_counting", i), counting, vecs[i].e_cnt);
      check($sformatf("vec%0d_remaining", i), remaining, vecs[i].e_rem);
      check($sformatf("vec%0d_tick", i), one_hz_enable, vecs[i].e_tick);
    end
    idle_inputs();

    // 1: driver delay 8 s -> 32 edges
    do_reset();
    start(2'b01);
    check("t1_counting", counting, 1);
    check("t1_remaining", remaining, 8);
    wait_expire("t1_expire_edges", 32);
    check("t1_rem_after", remaining, 0);
    check("t1_cnt_after", counting, 0);
    step();
    check("t1_single_pulse", expired, 0);

    // 2: reprogram passenger to 3 s, other params untouched
    do_reset();
    write_param(2'b10, 4'd3);
    start(2'b10);
    check("t2_remaining", remaining, 3);
    wait_expire("t2_pass_edges", 12);
    start(2'b00);
    wait_expire("t2_arm_edges", 24);
    start(2'b01);
    wait_expire("t2_driver_edges", 32);
    start(2'b11);
    wait_expire("t2_alarm_edges", 40);

    // 3: zero-length interval
    do_reset();
    write_param(2'b00, 4'd0);
    start(2'b00);
    check("t3_expired", expired, 1);
    check("t3_counting", counting, 0);
    step();
    check("t3_expired_next", expired, 0);
    check("t3_counting_next", counting, 0);

    // 4: restart with arm at cycle 9 of an alarm count
    do_reset();
    start(2'b11);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (expired) pulses++;
    end
    start(2'b00);
    if (expired) pulses++;
    check("t4_restart_rem", remaining, 6);
    check("t4_restart_cnt", counting, 1);
    check("t4_no_early_pulse", pulses, 0);
    wait_expire("t4_expire_edges", 24);

    // 5: abort by reprogram, then same-cycle start+reprogram
    do_reset();
    start(2'b01);
    for (int k = 1; k <= 9; k++) step();
    write_param(2'b00, 4'd6);
    check("t5_abort_cnt", counting, 0);
    check("t5_abort_rem", remaining, 0);
    check("t5_abort_exp", expired, 0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (expired || counting) pulses++;
    end
    check("t5_quiet_after_abort", pulses, 0);
    start_timer = 1'b1; interval = 2'b01;
    reprogram = 1'b1; time_param_sel = 2'b01; time_value = 4'd2;
    step();
    idle_inputs();
    check("t5_same_cycle_cnt", counting, 0);
    check("t5_same_cycle_rem", remaining, 0);
    start(2'b01);
    check("t5_written_value", remaining, 2);

    // 6: async reset mid-count restores defaults
    do_reset();
    write_param(2'b01, 4'd2);
    start(2'b01);
    check("t6_loaded", remaining, 2);
    step(); step();
    #2 reset = 1'b1;
    #1;
    check("t6_rst_cnt", counting, 0);
    check("t6_rst_rem", remaining, 0);
    check("t6_rst_exp", expired, 0);
    check("t6_rst_tick", one_hz_enable, 0);
    step();
    reset = 1'b0;
    start(2'b01);
    check("t6_default_restored", remaining, 8);
    wait_expire("t6_expire_edges", 32);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
